// File: rtl/pg_unmask.sv
// pg_unmask: output stage of the masked propagate/generate datapath.
// Takes 2-share masked p/g bits serially (LSB first, one bit position per
// beat), recombines them only on the way into its registers, ripples the
// carry and presents the unmasked WIDTH-bit sum plus carry-out on a
// valid/ready port.
// Optional feature macro: PG_UNMASK_CIN_EN adds a carry-in port (cin) that
// is used as the carry into bit 0.

// One sum bit: loads on its own beat, clears when the word is handed off.
module pg_unmask_bit (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // Bit register; a clear has priority since load and clear never coincide
  // (load happens in COLLECT, clear in HOLD).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_q <= 1'b0;
    else if (i_clr)  r_q <= 1'b0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

module pg_unmask #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             p0,
  input  logic             p1,
  input  logic             g0,
  input  logic             g1,
`ifdef PG_UNMASK_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;

  logic             w_p;
  logic             w_g;
  logic             w_cin0;
  logic             w_cy_in;
  logic             w_s;
  logic             w_cy_out;
  logic             w_accept;
  logic             w_last;
  logic             w_drain;
  logic [WIDTH-1:0] w_bit_load;
  logic [WIDTH-1:0] w_sum_q;

  // Shares are combined here and only feed register D inputs; no share is
  // ever stored on its own.
  assign w_p = p0 ^ p1;
  assign w_g = g0 ^ g1;

`ifdef PG_UNMASK_CIN_EN
  assign w_cin0 = cin;
`else
  assign w_cin0 = 1'b0;
`endif

  // Carry into the current position: external/zero carry for bit 0, the
  // rippled carry register for every later bit.
  assign w_cy_in  = (r_cnt == '0) ? w_cin0 : r_c;
  assign w_s      = w_p ^ w_cy_in;
  assign w_cy_out = w_g | (w_p & w_cy_in);

  // Handshake qualifiers are derived from the state register, not from the
  // combinational outputs, to keep the FSM free of loops.
  assign w_accept = in_valid && (r_state == COLLECT);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_drain  = (r_state == HOLD) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= COLLECT;
    else      r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      COLLECT: begin
        in_ready = 1'b1;
        if (w_accept && w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = COLLECT;
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // Beat counter and carry register; idle cycles leave both untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_c   <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      r_c   <= w_cy_out;
    end else if (w_drain) begin
      r_c   <= 1'b0;
    end
  end

  // One register cell per sum bit, selected by the beat counter.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_bit_load[i] = w_accept && (r_cnt == CNT_W'(i));

    pg_unmask_bit u_bit (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_bit_load[i]),
      .i_clr  (w_drain),
      .i_d    (w_s),
      .o_q    (w_sum_q[i])
    );
  end

  // Partial results stay hidden until the word is complete.
  assign sum  = (r_state == HOLD) ? w_sum_q : '0;
  assign cout = (r_state == HOLD) ? r_c : 1'b0;

endmodule

// File: tb/tb_pg_unmask.sv
// Directed self-checking bench for pg_unmask (WIDTH = 8).
// Builds with or without PG_UNMASK_CIN_EN; the carry-in step runs only when
// the macro is defined.
module tb_pg_unmask;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         p0, p1, g0, g1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PG_UNMASK_CIN_EN
  logic         cin;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pg_unmask #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p0        (p0),
    .p1        (p1),
    .g0        (g0),
    .g1        (g1),
`ifdef PG_UNMASK_CIN_EN
    .cin       (cin),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat (from a negedge) and hold it until it is accepted.
  task automatic send_beat(input logic bp, input logic bg, input logic mp, input logic mg);
    logic acc;
    int   tmo;
    in_valid = 1'b1;
    p0 = mp; p1 = bp ^ mp;
    g0 = mg; g1 = bg ^ mg;
    tmo = 0;
    do begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      tmo++;
    end while (!acc && tmo < 50);
    if (!acc) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  // Send a whole word of masked p/g, optionally with random idle gaps.
  // Checks that nothing is exposed before the last beat.
  task automatic send_word(input logic [W-1:0] p, input logic [W-1:0] g,
                           input logic [W-1:0] mp, input logic [W-1:0] mg,
                           input bit gaps, input bit chk_partial);
    for (int k = 0; k < W; k++) begin
      if (gaps) begin
        int n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) begin
          in_valid = 1'b0;
          p0 = 1'($urandom); p1 = 1'($urandom);
          g0 = 1'($urandom); g1 = 1'($urandom);
          @(negedge clk);
        end
      end
      send_beat(p[k], g[k], mp[k], mg[k]);
      if (chk_partial && k < W - 1) begin
        chk("partial_valid", 64'(out_valid), 64'd0);
        chk("partial_sum", 64'(sum), 64'd0);
      end
    end
    in_valid = 1'b0;
  endtask

  logic [W-1:0] m1, m2, held;
  int           t0, t1;

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    p0 = 1'b0; p1 = 1'b0; g0 = 1'b0; g1 = 1'b0;
`ifdef PG_UNMASK_CIN_EN
    cin = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst = 1'b1;

    // Reset mid-word after 3 beats; out_ready high during COLLECT is harmless.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) send_beat(1'b1, 1'b1, 1'($urandom), 1'($urandom));
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;

    // Fresh word after reset: 0x35 + 0x4A -> p=0x7F g=0x00 -> 0x7F, cout 0.
    m1 = W'($urandom); m2 = W'($urandom);
    send_word(8'h7F, 8'h00, m1, m2, 1'b0, 1'b1);
    chk("w1_out_valid", 64'(out_valid), 64'd1);
    chk("w1_in_ready", 64'(in_ready), 64'd0);
    chk("w1_sum", 64'(sum), 64'h7F);
    chk("w1_cout", 64'(cout), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("w1_drain_valid", 64'(out_valid), 64'd0);
    chk("w1_drain_ready", 64'(in_ready), 64'd1);
    chk("w1_drain_sum", 64'(sum), 64'd0);
    chk("w1_drain_cout", 64'(cout), 64'd0);

    // 0xFF + 0x01 -> p=0xFE g=0x01 -> 0x00, cout 1; all-ones masks first.
    send_word(8'hFE, 8'h01, 8'hFF, 8'hFF, 1'b0, 1'b1);
    chk("ones_sum", 64'(sum), 64'h00);
    chk("ones_cout", 64'(cout), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int r = 0; r < 100; r++) begin
      m1 = W'($urandom); m2 = W'($urandom);
      send_word(8'hFE, 8'h01, m1, m2, 1'b0, 1'b0);
      chk("rmask_valid", 64'(out_valid), 64'd1);
      chk("rmask_sum", 64'(sum), 64'h00);
      chk("rmask_cout", 64'(cout), 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    // Stall: gaps on input, out_ready low 5 cycles with junk beats offered.
    // 0x12 + 0x34 -> p=0x26 g=0x10 -> 0x46, cout 0.
    send_word(8'h26, 8'h10, W'($urandom), W'($urandom), 1'b1, 1'b1);
    held = sum;
    chk("stall_sum", 64'(held), 64'h46);
    in_valid = 1'b1; p0 = 1'b1; p1 = 1'b0; g0 = 1'b1; g1 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum_stable", 64'(sum), 64'h46);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_drain_valid", 64'(out_valid), 64'd0);
    // Next word only starts now; a lost or extra beat corrupts it.
    // 0xF0 + 0x10 -> p=0xE0 g=0x10 -> 0x00, cout 1.
    send_word(8'hE0, 8'h10, W'($urandom), W'($urandom), 1'b1, 1'b1);
    chk("after_stall_sum", 64'(sum), 64'h00);
    chk("after_stall_cout", 64'(cout), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);

    // Back-to-back with out_ready tied high: words land 9 cycles apart.
    send_word(8'h26, 8'h10, W'($urandom), W'($urandom), 1'b0, 1'b0);
    t0 = cyc;
    chk("b2b1_valid", 64'(out_valid), 64'd1);
    chk("b2b1_sum", 64'(sum), 64'h46);
    chk("b2b1_cout", 64'(cout), 64'd0);
    send_word(8'hE0, 8'h10, W'($urandom), W'($urandom), 1'b0, 1'b0);
    t1 = cyc;
    chk("b2b2_valid", 64'(out_valid), 64'd1);
    chk("b2b2_sum", 64'(sum), 64'h00);
    chk("b2b2_cout", 64'(cout), 64'd1);
    chk("b2b_spacing", 64'(t1 - t0), 64'd9);
    @(negedge clk);
    out_ready = 1'b0;

`ifdef PG_UNMASK_CIN_EN
    // cin=1, 0x7F + 0x00 -> 0x80, cout 0.
    cin = 1'b1;
    send_word(8'h7F, 8'h00, W'($urandom), W'($urandom), 1'b0, 1'b1);
    chk("cin_sum", 64'(sum), 64'h80);
    chk("cin_cout", 64'(cout), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cin = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pg_unmask.md
# pg_unmask

Output end of the masked propagate/generate datapath. Accepts first-order (2-share) masked propagate and generate bits from the masked PG core serially, LSB first, one bit position per handshake beat. Recombines the shares only inside its own registers, ripples the carry, and presents the unmasked WIDTH-bit sum and carry-out on a valid/ready output port. Sits between the registered masked PG core and the unmasked consumer.

## Interface
- WIDTH, 8, operand width in bits (number of beats per word); legal range 2..64
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  current beat's share bits are valid
- in_ready  output  1  block can accept a beat this cycle
- p0, p1  input  1  propagate shares for current bit position; p = p0 ^ p1
- g0, g1  input  1  generate shares for current bit position; g = g0 ^ g1
- out_valid  output  1  sum/cout hold a completed word
- out_ready  input  1  consumer takes the word this cycle
- sum  output  WIDTH  unmasked sum, bit i = result of beat i
- cout  output  1  carry out of bit WIDTH-1
- cin  input  1  carry-in, present only with PG_UNMASK_CIN_EN

## Operation
- States: COLLECT, HOLD. Reset state COLLECT.
- COLLECT: in_ready = 1, out_valid = 0. Beat accepted when in_valid && in_ready.
- On each accepted beat at position k (k = beat counter, 0..WIDTH-1):
  - p = p0 ^ p1, g = g0 ^ g1 (computed combinationally, used only to update registers)
  - sum bit k <= p ^ c; c <= g | (p & c)
  - c is the carry register; it is 0 (or cin, see Configuration) for k = 0
  - counter increments; on k = WIDTH-1 counter wraps to 0 and state -> HOLD
- Counter width is clog2(WIDTH). Beats are never dropped or reordered. Cycles with in_valid = 0 leave all state unchanged.
- HOLD: in_ready = 0, out_valid = 1. sum and cout = final c are stable. On out_ready = 1: state -> COLLECT, sum <= 0, c <= 0, cout <= 0.
- While out_valid = 0, sum and cout read 0. Partial results are never exposed.
- Share inputs are never registered individually. Only recombined p/g effects reach state.

## Timing
- Reset (rst low, asynchronous): state COLLECT, counter 0, c 0, in_ready 1, out_valid 0, sum 0, cout 0. Takes effect immediately, even mid-word. A partial word is discarded.
- First beat may be accepted in the first cycle after rst deasserts.
- Latency: out_valid rises the cycle after the WIDTH-th beat is accepted.
- Throughput: one word per WIDTH+1 cycles minimum. This is WIDTH beats plus one HOLD cycle with out_ready held at 1.
- in_ready drops in the same cycle out_valid rises and returns the cycle after the output handshake.
- In HOLD, in_valid is ignored. The upstream source must hold its beat.
- out_ready while out_valid = 0 has no effect.

## Configuration
- PG_UNMASK_CIN_EN defined:
  - cin port exists and is sampled on the beat with k = 0.
  - The carry into bit 0 is cin.
- PG_UNMASK_CIN_EN undefined:
  - No cin port.
  - The carry into bit 0 is constant 0.

## Test plan
- Reset then idle: hold rst low mid-word after 3 beats, release -> in_ready = 1, out_valid = 0, sum = 0x00, counter restarts. The next 8 beats form a fresh word.
- WIDTH=8, a=0x35, b=0x4A, sent as p=0x7F and g=0x00 with random masks m (p0 = m, p1 = p ^ m) -> sum = 0x7F, cout = 0, out_valid one cycle after beat 8.
- a=0xFF, b=0x01 (p=0xFE, g=0x01), masks all-ones -> sum = 0x00, cout = 1. Result must be independent of the mask values; repeat with 100 random masks.
- Stall: random in_valid gaps and out_ready held low 5 cycles -> in_ready stays 0 in HOLD, sum stable, no beat lost. The next word starts only after the handshake.
- Back-to-back: out_ready tied to 1, two words 0x12+0x34 and 0xF0+0x10 -> sums 0x46 then 0x00 with cout = 1. Words are 9 cycles apart.
- With PG_UNMASK_CIN_EN and cin=1, a=0x7F, b=0x00 -> sum = 0x80, cout = 0.
